wide_core: RTL and testbench
============================

WIDE_CORE -- requirements
Module: wide_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data and instruction word width, minimum 8.
REQ-002 SHALL have parameter ADDR_W, default 8: memory address and pc width.
REQ-003 SHALL have parameter NREGS, default 2: register count, a power of two; RSEL_W = log2(NREGS), minimum 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port addr, output, ADDR_W: memory address.
REQ-007 SHALL have port data_out, output, DATA_W: write data.
REQ-008 SHALL have port data_in, input, DATA_W: read data, valid in the cycle mem_ready is high.
REQ-009 SHALL have port we, output, 1: write enable, meaningful only while mem_req is high.
REQ-010 SHALL have port mem_req, output, 1: memory request.
REQ-011 SHALL have port mem_ready, input, 1: transfer done, sampled only while mem_req is high.
REQ-012 SHALL have port halted, output, 1: high while in HALT.

Function
REQ-013 SHALL decode each instruction word with op = [DATA_W-1:DATA_W-3], rd = next RSEL_W bits, and field = remaining AF_W = DATA_W-3-RSEL_W bits; elaboration SHALL fail if AF_W < 1.
REQ-014 SHALL form the effective address from field, zero-extended or truncated to ADDR_W.
REQ-015 SHALL execute the opcodes as follows: 000 JMP pc=ea; 001 LOD rd=mem[ea]; 010 STR mem[ea]=rd; 011 ADD rd=rd+mem[ea]; 100 SUB rd=rd-mem[ea]; 101 JZ pc=ea if rd==0, else pc+1; 110 LDI rd=zero-extended field; 111 HLT.
REQ-016 SHALL perform ADD and SUB modulo 2^DATA_W, discarding carry and borrow.
REQ-017 SHALL increment pc modulo 2^ADDR_W, so all-ones wraps to 0.
REQ-018 SHALL implement the state machine RST_IDLE -> F_REQ -> EXEC -> {F_REQ | M_REQ -> WB -> F_REQ | HALT}.
REQ-019 SHALL, in F_REQ, drive mem_req=1, we=0, addr=pc, hold there until mem_ready, latch data_in as the instruction, then go to EXEC.
REQ-020 SHALL, in EXEC, complete JMP, JZ and LDI (register/pc update) and go to F_REQ; send LOD, STR, ADD and SUB to M_REQ; send HLT to HALT.
REQ-021 SHALL, in M_REQ, drive mem_req=1, addr=ea, with we=1 and data_out=rd for STR only, and wait for mem_ready.
REQ-022 SHALL, in WB, write rd for LOD, ADD and SUB (no write for STR), set pc=pc+1, and go to F_REQ.
REQ-023 SHALL hold addr, we and data_out stable for the whole time mem_req is high.
REQ-024 SHALL drop mem_req in the cycle after mem_ready is sampled high, with exactly one transfer per request.
REQ-025 SHALL give, with zero-wait memory, 2 cycles for non-memory instructions and 4 cycles for memory instructions.
REQ-026 SHALL hold HALT with mem_req=0 until rst.
REQ-027 SHALL ignore mem_ready while mem_req is low.

Reset
REQ-028 SHALL, while rst is high, force immediately (no clock needed): pc=0, all registers 0, state RST_IDLE, mem_req=0, we=0, addr=0, data_out=0, halted=0.
REQ-029 SHALL abandon any transfer in progress when rst asserts; an outstanding STR SHALL NOT be retried.
REQ-030 SHALL enter F_REQ on the first clk edge after rst deasserts, with the first mem_req high in the following cycle at addr=0.

Configuration
REQ-031 SHALL support macro WIDE_CORE_HLT_EN: when defined, op 111 enters HALT and halted operates as specified.
REQ-032 SHALL, without WIDE_CORE_HLT_EN, treat op 111 as NOP (EXEC -> F_REQ, pc+1), tie halted to 0, and omit the HALT state.

Verification (DATA_W=8, ADDR_W=8, NREGS=2; encoding op[7:5] rd[4] field[3:0])
REQ-033 SHALL cover: mem 0:C5,1:68,2:49,3:E0, mem[8]=FD -> mem[9]=02 written once; halted=1 after fetch at 3; mem_req then stays 0.
REQ-034 SHALL cover: 0:D0,1:B4,4:E0 -> fetch address sequence 00,01,04, then halted=1.
REQ-035 SHALL cover: mem_ready delayed 3 cycles on every access -> mem_req, addr and we stable for 4 cycles per access, and results identical to REQ-033.
REQ-036 SHALL cover: all 256 locations = C1 -> fetch addr goes FF then 00; r0 = 01.
REQ-037 SHALL cover: rst pulsed mid-M_REQ of STR (between clk edges) -> mem_req=0 immediately, no write, next fetch at addr 00.
REQ-038 SHALL cover: build without WIDE_CORE_HLT_EN running the REQ-033 program -> E0 acts as NOP; fetch continues at 04; halted stays 0.

Source files
------------

// File: rtl/wide_core.sv
// wide_core: small accumulator-style CPU with a single shared memory port.
//
// Instruction word (DATA_W bits): op[DATA_W-1:DATA_W-3], rd (RSEL_W bits),
// field (remaining AF_W bits). The field is both the effective address
// (zero-extended/truncated to ADDR_W) and the LDI immediate.
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - asynchronous active-high reset
//   addr      - memory address (pc during fetch, ea during data access)
//   data_out  - write data (register value during STR, else 0)
//   data_in   - read data, valid while mem_ready is high
//   we        - write enable, meaningful only while mem_req is high
//   mem_req   - memory request, held until mem_ready is seen
//   mem_ready - transfer done, ignored while mem_req is low
//   halted    - high while in HALT
//
// Build option: define WIDE_CORE_HLT_EN to make op 111 halt the core;
// without it op 111 is a NOP and halted is tied low.
module wide_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              we,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              halted
);
  localparam int RSEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int AF_W   = DATA_W - 3 - RSEL_W;

  generate
    if (AF_W < 1) begin : g_af_w_check
      $error("wide_core: DATA_W leaves no address field bits for this NREGS");
    end
  endgenerate

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_LOD = 3'b001;
  localparam logic [2:0] OP_STR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_RST_IDLE,
    S_F_REQ,
    S_EXEC,
    S_M_REQ,
`ifdef WIDE_CORE_HLT_EN
    S_HALT,
`endif
    S_WB
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_mdr;
  logic [DATA_W-1:0]   r_regs [NREGS];

  logic [2:0]          w_op;
  logic [RSEL_W-1:0]   w_rd;
  logic [AF_W-1:0]     w_field;
  logic [ADDR_W-1:0]   w_ea;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_rd_val;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_wr_data;
  logic [NREGS-1:0]    w_reg_we;

  // Decode always works from the latched instruction, so addr/we/data_out
  // stay constant for the whole M_REQ phase.
  assign w_op     = r_ir[DATA_W-1 -: 3];
  assign w_rd     = r_ir[DATA_W-4 -: RSEL_W];
  assign w_field  = r_ir[AF_W-1:0];
  assign w_imm    = {{(DATA_W-AF_W){1'b0}}, w_field};
  assign w_rd_val = r_regs[w_rd];
  assign w_pc_inc = r_pc + ADDR_W'(1);

  generate
    if (AF_W >= ADDR_W) begin : g_ea_trunc
      assign w_ea = w_field[ADDR_W-1:0];
    end else begin : g_ea_zext
      assign w_ea = {{(ADDR_W-AF_W){1'b0}}, w_field};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RST_IDLE: w_state_next = S_F_REQ;
      S_F_REQ:    if (mem_ready) w_state_next = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_LOD, OP_STR, OP_ADD, OP_SUB: w_state_next = S_M_REQ;
`ifdef WIDE_CORE_HLT_EN
          OP_HLT:                         w_state_next = S_HALT;
`endif
          default:                        w_state_next = S_F_REQ;
        endcase
      end
      S_M_REQ:    if (mem_ready) w_state_next = S_WB;
      S_WB:       w_state_next = S_F_REQ;
`ifdef WIDE_CORE_HLT_EN
      S_HALT:     w_state_next = S_HALT;
`endif
      default:    w_state_next = S_RST_IDLE;
    endcase
  end

  // Bus outputs decode purely from registered state, so reset clears them
  // immediately without waiting for a clock.
  always_comb begin
    mem_req  = 1'b0;
    we       = 1'b0;
    addr     = '0;
    data_out = '0;
    halted   = 1'b0;
    case (r_state)
      S_F_REQ: begin
        mem_req = 1'b1;
        addr    = r_pc;
      end
      S_M_REQ: begin
        mem_req = 1'b1;
        addr    = w_ea;
        if (w_op == OP_STR) begin
          we       = 1'b1;
          data_out = w_rd_val;
        end
      end
`ifdef WIDE_CORE_HLT_EN
      S_HALT:  halted = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    if (r_state == S_EXEC) begin
      case (w_op)
        OP_JMP:  w_pc_next = w_ea;
        OP_JZ:   w_pc_next = (w_rd_val == '0) ? w_ea : w_pc_inc;
        OP_LDI:  w_pc_next = w_pc_inc;
`ifndef WIDE_CORE_HLT_EN
        OP_HLT:  w_pc_next = w_pc_inc;
`endif
        // memory ops advance pc in WB; a halting HLT leaves pc frozen
        default: w_pc_next = r_pc;
      endcase
    end else if (r_state == S_WB) begin
      w_pc_next = w_pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= '0;
    else     r_pc <= w_pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir  <= '0;
      r_mdr <= '0;
    end else begin
      if (r_state == S_F_REQ && mem_ready) r_ir  <= data_in;
      if (r_state == S_M_REQ && mem_ready) r_mdr <= data_in;
    end
  end

  // Register writeback: LDI commits in EXEC, LOD/ADD/SUB commit in WB.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = w_imm;
    if (r_state == S_EXEC && w_op == OP_LDI) begin
      w_wr_en   = 1'b1;
      w_wr_data = w_imm;
    end else if (r_state == S_WB) begin
      case (w_op)
        OP_LOD: begin w_wr_en = 1'b1; w_wr_data = r_mdr;            end
        OP_ADD: begin w_wr_en = 1'b1; w_wr_data = w_rd_val + r_mdr; end
        OP_SUB: begin w_wr_en = 1'b1; w_wr_data = w_rd_val - r_mdr; end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg_we
      assign w_reg_we[gi] = w_wr_en && (w_rd == RSEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_reg_we[i]) r_regs[i] <= w_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wide_core.sv
// Testbench for wide_core (DATA_W=8, ADDR_W=8, NREGS=2). A behavioural memory
// with configurable wait states answers the core; every completed transfer is
// logged and compared against an instruction-level model of the ISA.
module tb_wide_core;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int NREGS  = 2;
`ifdef WIDE_CORE_HLT_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } tx_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr, data_out, data_in;
  logic       we, mem_req, halted;
  logic       mem_ready = 1'b0;

  tx_t        obs_q[$];
  tx_t        exp_q[$];
  logic [7:0] mem      [256];
  logic [7:0] init_mem [256];
  logic [7:0] m_mem    [256];
  logic [7:0] m_regs   [2];
  bit         m_halted;
  int         m_cycles;
  int         lat = 0;
  int         rsp_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       prev_req = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [16:0] prev_bus = '0;

  always #5 clk = ~clk;

  assign data_in = mem[addr];

  wide_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_out(data_out), .data_in(data_in),
    .we(we), .mem_req(mem_req), .mem_ready(mem_ready), .halted(halted)
  );

  // Memory responder and bus monitor, all at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      rsp_cnt   = 0;
      mem_ready = 1'b0;
      prev_req  = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (mem_req && prev_req && !prev_xfer) begin
        n_checks++;
        if ({we, addr, data_out} !== prev_bus) begin
          n_fail++;
          $display("FAIL bus_stable: got %h, required %h", {we, addr, data_out}, prev_bus);
        end
      end
      if (prev_xfer) begin
        n_checks++;
        if (mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL req_drop: mem_req=%b after transfer, required 0", mem_req);
        end
      end
      if (halted === 1'b1) begin
        n_checks++;
        if (mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL halt_quiet: mem_req=%b while halted, required 0", mem_req);
        end
      end
      prev_req = mem_req;
      prev_bus = {we, addr, data_out};
      if (mem_req) begin
        if (rsp_cnt == lat) begin
          mem_ready = 1'b1;
          rsp_cnt   = 0;
          obs_q.push_back(tx_t'({we, addr, (we ? data_out : mem[addr])}));
          $display("tx %0t we=%0d addr=%02h data=%02h", $time, we, addr, (we ? data_out : mem[addr]));
          if (we) mem[addr] = data_out;
        end else begin
          mem_ready = 1'b0;
          rsp_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        rsp_cnt   = 0;
      end
      prev_xfer = mem_ready;
    end
  end

  // Instruction-level reference: executes the ISA directly on a copy of
  // init_mem and lists the bus transfers it implies, plus the cycle count
  // (fetch 1+lat, execute 1, and for memory ops access 1+lat, writeback 1).
  task automatic model_run(input int max_tx, input int latency);
    logic [7:0] pc, ir, ea, v;
    int rd;
    exp_q.delete();
    pc = 8'h00;
    m_regs[0] = 8'h00;
    m_regs[1] = 8'h00;
    m_halted = 1'b0;
    m_cycles = 1;
    for (int i = 0; i < 256; i++) m_mem[i] = init_mem[i];
    while (!m_halted && exp_q.size() < max_tx) begin
      ir = m_mem[pc];
      exp_q.push_back(tx_t'({1'b0, pc, ir}));
      rd = int'(ir[4]);
      ea = {4'h0, ir[3:0]};
      m_cycles += 2 + latency;
      case (ir[7:5])
        3'd0: pc = ea;
        3'd5: pc = (m_regs[rd] == 8'h00) ? ea : pc + 8'h01;
        3'd6: begin m_regs[rd] = ea; pc = pc + 8'h01; end
        3'd7: if (HLT_EN) m_halted = 1'b1; else pc = pc + 8'h01;
        default: begin
          m_cycles += 2 + latency;
          v = m_mem[ea];
          if (ir[7:5] == 3'd2) begin
            if (exp_q.size() < max_tx) exp_q.push_back(tx_t'({1'b1, ea, m_regs[rd]}));
            m_mem[ea] = m_regs[rd];
          end else begin
            if (exp_q.size() < max_tx) exp_q.push_back(tx_t'({1'b0, ea, v}));
            if (ir[7:5] == 3'd1) m_regs[rd] = v;
            else if (ir[7:5] == 3'd3) m_regs[rd] = m_regs[rd] + v;
            else m_regs[rd] = m_regs[rd] - v;
          end
          pc = pc + 8'h01;
        end
      endcase
    end
  endtask

  task automatic start(input int latency);
    rst = 1'b1;
    lat = latency;
    for (int i = 0; i < 256; i++) mem[i] = init_mem[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs_q.delete();
    rst = 1'b0;
  endtask

  task automatic run_dut(input int max_tx, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget && halted !== 1'b1 && obs_q.size() < max_tx) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic load_033();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    init_mem[0] = 8'hC5; init_mem[1] = 8'h68; init_mem[2] = 8'h49; init_mem[3] = 8'hE0;
    init_mem[8] = 8'hFD;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, we, addr, data_out, halted} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_async: outputs %h, required 0", {mem_req, we, addr, data_out, halted});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({mem_req, we, addr, data_out, halted} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_held: outputs %h, required 0", {mem_req, we, addr, data_out, halted});
    end
    load_033();
    start(0);
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: mem_req=%b before first edge, required 0", mem_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b1 || addr !== 8'h00 || we !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch: mem_req=%b addr=%02h we=%b, required 1/00/0", mem_req, addr, we);
    end
  endtask

  task automatic test_store_halt(input int latency);
    int cyc, nw_obs, nw_exp;
    load_033();
    model_run(12, latency);
    start(latency);
    run_dut(12, 400, cyc);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL store_len lat=%0d: got %0d transfers, required %0d", latency, obs_q.size(), exp_q.size());
    end
    nw_obs = 0; nw_exp = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL store_tx[%0d] lat=%0d: got %h, required %h", i, latency, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].we) nw_obs++;
      if (exp_q[i].we) nw_exp++;
    end
    n_checks++;
    if (mem[9] !== m_mem[9] || nw_obs != nw_exp) begin
      n_fail++;
      $display("FAIL store_write: mem9=%02h writes=%0d, required %02h writes=%0d", mem[9], nw_obs, m_mem[9], nw_exp);
    end
    n_checks++;
    if (halted !== m_halted) begin
      n_fail++;
      $display("FAIL store_halted: got %b, required %b", halted, m_halted);
    end
    if (m_halted) begin
      n_checks++;
      if (cyc != m_cycles) begin
        n_fail++;
        $display("FAIL store_cycles lat=%0d: got %0d, required %0d", latency, cyc, m_cycles);
      end
      repeat (8) @(posedge clk);
      #1;
      n_checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_hold: halted=%b mem_req=%b, required 1/0", halted, mem_req);
      end
    end
  endtask

  task automatic test_jz();
    int cyc;
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    init_mem[0] = 8'hD0; init_mem[1] = 8'hB4; init_mem[4] = 8'hE0;
    model_run(8, 0);
    start(0);
    run_dut(8, 200, cyc);
    n_checks++;
    if (obs_q.size() != exp_q.size() || halted !== m_halted) begin
      n_fail++;
      $display("FAIL jz_len: got %0d/%b, required %0d/%b", obs_q.size(), halted, exp_q.size(), m_halted);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL jz_tx[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_pc_wrap();
    int cyc;
    for (int i = 0; i < 256; i++) init_mem[i] = 8'hC1;
    model_run(260, 0);
    start(0);
    run_dut(260, 1000, cyc);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_len: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_tx[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (dut.r_regs[0] !== m_regs[0]) begin
      n_fail++;
      $display("FAIL wrap_r0: got %02h, required %02h", dut.r_regs[0], m_regs[0]);
    end
  endtask

  task automatic test_reset_mid_store();
    int k, cyc;
    load_033();
    start(3);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (we === 1'b1) break;
    end
    n_checks++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL midrst_wait: store request not seen within 100 cycles");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, we, addr, data_out, halted} !== 19'd0) begin
      n_fail++;
      $display("FAIL midrst_async: outputs %h, required 0", {mem_req, we, addr, data_out, halted});
    end
    obs_q.delete();
    #1 rst = 1'b0;
    run_dut(1, 40, cyc);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== tx_t'({1'b0, 8'h00, 8'hC5}) || mem[9] !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_refetch: n=%0d first=%h mem9=%02h, required 1/00c5/00", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : tx_t'(0), mem[9]);
    end
  endtask

  task automatic test_random();
    int cyc, l;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 256; i++) begin
        init_mem[i] = 8'($urandom);
        if (init_mem[i][7:5] == 3'b111 && $urandom_range(0, 3) != 0) init_mem[i][7:5] = 3'b011;
      end
      l = $urandom_range(0, 2);
      model_run(50, l);
      start(l);
      run_dut(50, 2000, cyc);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_len: got %0d, required %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_tx[%0d]: got %h, required %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      if (m_halted) begin
        n_checks++;
        if (cyc != m_cycles || halted !== 1'b1) begin
          n_fail++;
          $display("FAIL rand%0d_cycles: got %0d/%b, required %0d/1", it, cyc, halted, m_cycles);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_halt(0);
    test_jz();
    test_store_halt(3);
    test_pc_wrap();
    test_reset_mid_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
